// File: rtl/state_commit_ctrl.sv
// Commits a multi-bit state word that was synchronized into the VGA domain. A value is accepted only
// after it has been stable for STABLE_CYCLES samples, and it is presented only during an unfrozen vblank.
module state_commit_ctrl #(
  parameter int BITS          = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk_vga,
  input  logic            rst_n,
  input  logic [BITS-1:0] state_sync,
  input  logic            vblank,
  input  logic            freeze,
  output logic [BITS-1:0] state_commit,
  output logic            commit_pulse,
  output logic            busy,
  output logic [7:0]      restart_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   CNT_TARGET = (CW + 1)'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    WAIT_VB = 2'd2
  } state_t;

  // A freshly loaded candidate is already fully settled when one sample suffices.
  localparam state_t LOAD_STATE = (STABLE_CYCLES == 1) ? WAIT_VB : SETTLE;

  state_t            state_q, state_d;
  logic [BITS-1:0]   cand_q, cand_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]   commit_d;
  logic              pulse_d;
  logic [7:0]        restart_d;
  logic [7:0]        restart_sat;
  logic [CW:0]       cnt_inc;

  assign restart_sat = (restart_cnt == 8'hFF) ? restart_cnt : restart_cnt + 8'd1;
  assign cnt_inc     = {1'b0, cnt_q} + (CW + 1)'(1);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      state_commit <= '0;
      commit_pulse <= 1'b0;
      busy         <= 1'b0;
      restart_cnt  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      state_commit <= commit_d;
      commit_pulse <= pulse_d;
      busy         <= (state_d != IDLE);
      restart_cnt  <= restart_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    commit_d  = state_commit;
    pulse_d   = 1'b0;
    restart_d = restart_cnt;
    case (state_q)
      IDLE: begin
        if (state_sync != state_commit) begin
          cand_d  = state_sync;
          cnt_d   = CNT_ONE;
          state_d = LOAD_STATE;
        end
      end
      SETTLE: begin
        if (state_sync == state_commit) begin
          state_d   = IDLE;
          restart_d = restart_sat;
        end else if (state_sync != cand_q) begin
          cand_d    = state_sync;
          cnt_d     = CNT_ONE;
          restart_d = restart_sat;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[CW-1:0];
          if (cnt_inc == CNT_TARGET) state_d = WAIT_VB;
        end
      end
      WAIT_VB: begin
        // A change wins over vblank so a stale candidate is never committed.
        if (state_sync != cand_q) begin
          restart_d = restart_sat;
          if (state_sync == state_commit) begin
            state_d = IDLE;
          end else begin
            cand_d  = state_sync;
            cnt_d   = CNT_ONE;
            state_d = LOAD_STATE;
          end
        end else if (vblank && !freeze) begin
          commit_d = cand_q;
          pulse_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_state_commit_ctrl.sv
// Bench for state_commit_ctrl: two builds (STABLE_CYCLES=4 and 1) share stimulus and are checked each
// cycle against a run-length reference model, plus directed scenario checks.
module tb_state_commit_ctrl;

  logic       clk_vga = 1'b0;
  logic       rst_n;
  logic [7:0] state_sync;
  logic       vblank;
  logic       freeze;

  logic [7:0] commit_a, commit_b;
  logic       pulse_a, pulse_b;
  logic       busy_a, busy_b;
  logic [7:0] rcnt_a, rcnt_b;

  int checks   = 0;
  int failures = 0;

  // reference model state, index 0 = STABLE_CYCLES 4, index 1 = STABLE_CYCLES 1
  int         m_sc[2] = '{4, 1};
  logic [7:0] m_commit[2];
  logic [7:0] m_cand[2];
  int         m_run[2];
  logic       m_active[2];
  logic       m_pulse[2];
  int         m_restart[2];

  always #5 clk_vga = ~clk_vga;

  state_commit_ctrl #(.BITS(8), .STABLE_CYCLES(4)) dut_a (
    .clk_vga(clk_vga), .rst_n(rst_n), .state_sync(state_sync), .vblank(vblank), .freeze(freeze),
    .state_commit(commit_a), .commit_pulse(pulse_a), .busy(busy_a), .restart_cnt(rcnt_a)
  );

  state_commit_ctrl #(.BITS(8), .STABLE_CYCLES(1)) dut_b (
    .clk_vga(clk_vga), .rst_n(rst_n), .state_sync(state_sync), .vblank(vblank), .freeze(freeze),
    .state_commit(commit_b), .commit_pulse(pulse_b), .busy(busy_b), .restart_cnt(rcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_commit[k] = 8'h00; m_cand[k] = 8'h00; m_run[k] = 0;
      m_active[k] = 1'b0; m_pulse[k] = 1'b0; m_restart[k] = 0;
    end
  endtask

  // Candidate run-length view: a candidate is eligible once seen STABLE_CYCLES times in a row,
  // and is committed on a later edge where vblank is high and freeze is low.
  task automatic model_step(input int k);
    m_pulse[k] = 1'b0;
    if (!rst_n) begin
      m_commit[k] = 8'h00; m_cand[k] = 8'h00; m_run[k] = 0; m_active[k] = 1'b0; m_restart[k] = 0;
    end else if (!m_active[k]) begin
      if (state_sync != m_commit[k]) begin
        m_active[k] = 1'b1; m_cand[k] = state_sync; m_run[k] = 1;
      end
    end else if (state_sync != m_cand[k]) begin
      if (m_restart[k] < 255) m_restart[k]++;
      if (state_sync == m_commit[k]) m_active[k] = 1'b0;
      else begin m_cand[k] = state_sync; m_run[k] = 1; end
    end else if (m_run[k] >= m_sc[k] && vblank && !freeze) begin
      m_commit[k] = m_cand[k]; m_pulse[k] = 1'b1; m_active[k] = 1'b0;
    end else if (m_run[k] < m_sc[k]) begin
      m_run[k]++;
    end
  endtask

  task automatic check_model();
    chk("A.state_commit", commit_a, m_commit[0]);
    chk("A.commit_pulse", pulse_a, m_pulse[0]);
    chk("A.busy", busy_a, m_active[0]);
    chk("A.restart_cnt", rcnt_a, m_restart[0]);
    chk("B.state_commit", commit_b, m_commit[1]);
    chk("B.commit_pulse", pulse_b, m_pulse[1]);
    chk("B.busy", busy_b, m_active[1]);
    chk("B.restart_cnt", rcnt_b, m_restart[1]);
  endtask

  task automatic tick();
    @(posedge clk_vga);
    model_step(0);
    model_step(1);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, holds it over one edge, releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] vals[4] = '{8'h3C, 8'h5A, 8'hC3, 8'h00};
  int         r;

  initial begin
    rst_n = 1'b0; state_sync = 8'h00; vblank = 1'b0; freeze = 1'b0;
    model_reset();
    ticks(2);
    chk("reset.state_commit", commit_a, 8'h00);
    chk("reset.busy", busy_a, 1'b0);
    rst_n = 1'b1;
    tick();

    // basic commit latency
    state_sync = 8'h3C; vblank = 1'b1; freeze = 1'b0;
    ticks(4);
    chk("t1.busy_edge4", busy_a, 1'b1);
    chk("t1.no_commit_edge4", commit_a, 8'h00);
    tick();
    chk("t1.commit_edge5", commit_a, 8'h3C);
    chk("t1.pulse_edge5", pulse_a, 1'b1);
    tick();
    chk("t1.pulse_single", pulse_a, 1'b0);

    // skew: one intermediate sample, one restart, only the final value commits
    do_reset();
    state_sync = 8'h0C; vblank = 1'b1;
    tick();
    state_sync = 8'h3C;
    ticks(5);
    chk("t2.restart_cnt", rcnt_a, 8'd1);
    chk("t2.commit", commit_a, 8'h3C);

    // long wait outside vblank
    state_sync = 8'h5A; vblank = 1'b0;
    ticks(100);
    chk("t3.held", commit_a, 8'h3C);
    vblank = 1'b1;
    tick();
    chk("t3.commit", commit_a, 8'h5A);
    chk("t3.pulse", pulse_a, 1'b1);

    // change arrives in the same cycle vblank rises
    state_sync = 8'h3C; vblank = 1'b0;
    ticks(5);
    state_sync = 8'hC3; vblank = 1'b1;
    tick();
    chk("t4.no_stale", commit_a, 8'h5A);
    ticks(3);
    chk("t4.still_settling", commit_a, 8'h5A);
    tick();
    chk("t4.commit", commit_a, 8'hC3);

    // freeze holds across vblank, commit in a later unfrozen vblank
    state_sync = 8'h3C; freeze = 1'b1; vblank = 1'b1;
    ticks(10);
    chk("t5.frozen", commit_a, 8'hC3);
    vblank = 1'b0;
    ticks(3);
    vblank = 1'b1; freeze = 1'b0;
    tick();
    chk("t5.commit", commit_a, 8'h3C);

    // glitch returning to the committed value
    do_reset();
    state_sync = 8'h3C;
    ticks(2);
    state_sync = 8'h00;
    tick();
    chk("t5.glitch_idle", busy_a, 1'b0);
    chk("t5.glitch_restart", rcnt_a, 8'd1);
    chk("t5.glitch_no_commit", commit_a, 8'h00);

    // reset in the middle of settling
    state_sync = 8'h77; vblank = 1'b1;
    ticks(2);
    do_reset();
    chk("t6.reset_busy", busy_a, 1'b0);
    chk("t6.reset_commit", commit_a, 8'h00);

    // single-sample build commits two edges after a change
    state_sync = 8'h11; vblank = 1'b1;
    tick();
    chk("t6.sc1_busy", busy_b, 1'b1);
    chk("t6.sc1_wait", commit_b, 8'h00);
    tick();
    chk("t6.sc1_commit", commit_b, 8'h11);
    chk("t6.sc1_pulse", pulse_b, 1'b1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 8) state_sync = vals[$urandom_range(0, 3)];
      else if (r < 11) state_sync = 8'($urandom_range(0, 255));
      vblank = ((c % 40) >= 30);
      freeze = ($urandom_range(0, 7) == 0);
      rst_n  = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
